// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: FSM encoding, byte-enable width,
// the pipeline register-index width and the byte-enable helper.
package mem_access_pkg;

  localparam int REG_IDX_W = 4;
  localparam int BE_W      = 4;

  typedef logic [BE_W-1:0] be_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Byte access enables the single addressed lane; word access enables all lanes.
  function automatic be_t byte_enable(input logic byte_acc, input logic [1:0] offset);
    if (byte_acc) return be_t'(1) << offset;
    return '1;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Load-data alignment: byte-lane select with zero-extension, and optional rotation
// of unaligned word loads when MEM_ACCESS_UNALIGNED_ROT_EN is defined.
module mem_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic        byte_i,
  output logic [31:0] data_o
);

  logic [4:0] shamt;
  logic [7:0] lane;

  assign shamt = {offset_i, 3'b000};

  always_comb begin
    lane   = 8'(rdata_i >> shamt);
    data_o = rdata_i;
`ifdef MEM_ACCESS_UNALIGNED_ROT_EN
    if (offset_i != 2'b00) data_o = 32'({rdata_i, rdata_i} >> shamt);
`else
    // Unaligned word loads return the aligned word as-is.
`endif
    if (byte_i) data_o = {24'h0, lane};
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through in one cycle, or runs a
// single bus transaction for loads/stores while stalling upstream.
// Optional feature: MEM_ACCESS_UNALIGNED_ROT_EN (rotating unaligned word loads, in mem_align).
module mem_access
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [REG_IDX_W-1:0] dest_i,
  input  logic                 write_dest_do_i,
  input  logic                 write_dest_m_i,
  input  logic                 write_cpsr_i,
  input  logic                 load_i,
  input  logic                 store_i,
  input  logic                 byte_i,
  input  logic [31:0]          result_i,
  input  logic [31:0]          store_data_i,
  input  logic [63:0]          m_result_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [BE_W-1:0]      mem_be_o,
  input  logic                 mem_ack_i,
  input  logic [31:0]          mem_rdata_i,
  output logic [REG_IDX_W-1:0] dest_o,
  output logic                 write_dest_do_o,
  output logic                 write_dest_m_o,
  output logic                 write_cpsr_o,
  output logic [31:0]          result_o,
  output logic [63:0]          m_result_o,
  output logic                 stall_o
);

  logic [1:0]           state_q, state_d;
  logic [REG_IDX_W-1:0] dest_q, dest_d, mem_dest_q, mem_dest_d;
  logic                 wdo_q, wdo_d, wdm_q, wdm_d, wcpsr_q, wcpsr_d;
  logic [31:0]          result_q, result_d;
  logic [63:0]          m_result_q, m_result_d;
  logic                 we_q, we_d, byte_q, byte_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [1:0]           offset_q, offset_d;
  logic [31:0]          load_data;

  mem_align u_align (
    .rdata_i  (mem_rdata_i),
    .offset_i (offset_q),
    .byte_i   (byte_q),
    .data_o   (load_data)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so each path assigns everything and no latch is inferred.
    state_d    = state_q;
    dest_d     = dest_q;
    mem_dest_d = mem_dest_q;
    wdo_d      = wdo_q;
    wdm_d      = wdm_q;
    wcpsr_d    = wcpsr_q;
    result_d   = result_q;
    m_result_d = m_result_q;
    we_d       = we_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    offset_d   = offset_q;

    case (state_q)
      ST_IDLE: begin
        wdo_d   = 1'b0;
        wdm_d   = 1'b0;
        wcpsr_d = 1'b0;
        if (valid_i) begin
          if (load_i || store_i) begin
            state_d    = ST_BUS;
            mem_dest_d = dest_i;
            we_d       = store_i & ~load_i;
            byte_d     = byte_i;
            addr_d     = {result_i[31:2], 2'b00};
            offset_d   = result_i[1:0];
            be_d       = byte_enable(byte_i, result_i[1:0]);
            wdata_d    = byte_i ? {4{store_data_i[7:0]}} : store_data_i;
          end else begin
            dest_d     = dest_i;
            wdo_d      = write_dest_do_i;
            wdm_d      = write_dest_m_i;
            wcpsr_d    = write_cpsr_i;
            result_d   = result_i;
            m_result_d = m_result_i;
          end
        end
      end
      ST_BUS: begin
        // Read data is only trusted on the ack edge; stores complete with flags still low.
        if (mem_ack_i) begin
          state_d = ST_DONE;
          if (!we_q) begin
            dest_d   = mem_dest_q;
            wdo_d    = 1'b1;
            result_d = load_data;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        wdo_d   = 1'b0;
        wdm_d   = 1'b0;
        wcpsr_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      dest_q     <= '0;
      mem_dest_q <= '0;
      wdo_q      <= 1'b0;
      wdm_q      <= 1'b0;
      wcpsr_q    <= 1'b0;
      result_q   <= '0;
      m_result_q <= '0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      offset_q   <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      mem_dest_q <= mem_dest_d;
      wdo_q      <= wdo_d;
      wdm_q      <= wdm_d;
      wcpsr_q    <= wcpsr_d;
      result_q   <= result_d;
      m_result_q <= m_result_d;
      we_q       <= we_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      offset_q   <= offset_d;
    end
  end

  assign mem_req_o       = (state_q == ST_BUS);
  assign stall_o         = (state_q == ST_BUS);
  assign mem_we_o        = we_q;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_be_o        = be_q;
  assign dest_o          = dest_q;
  assign write_dest_do_o = wdo_q;
  assign write_dest_m_o  = wdm_q;
  assign write_cpsr_o    = wcpsr_q;
  assign result_o        = result_q;
  assign m_result_o      = m_result_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL expose: clk  input  1  single clock, all state on rising edge.
REQ-002 The block SHALL expose: rst  input  1  synchronous, active-high reset.
REQ-003 The block SHALL expose execute-side inputs: valid_i 1; dest_i 4; write_dest_do_i 1; write_dest_m_i 1; write_cpsr_i 1; load_i 1; store_i 1; byte_i 1, byte access; result_i 32, ALU result or effective address; store_data_i 32; m_result_i 64.
REQ-004 The block SHALL expose bus ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out 32; mem_wdata_o out 32; mem_be_o out 4, byte enables; mem_ack_i in 1; mem_rdata_i in 32.
REQ-005 The block SHALL expose write-back-side outputs: dest_o 4; write_dest_do_o 1; write_dest_m_o 1; write_cpsr_o 1; result_o 32; m_result_o 64.
REQ-006 The block SHALL expose stall_o  output  1: upstream must hold its inputs while it is high.

Function
REQ-007 The FSM SHALL have states IDLE, BUS, DONE.
REQ-008 In IDLE, when valid_i is high and neither load_i nor store_i is high, the block SHALL register dest/flags/result_i/m_result_i to the outputs at the next edge, giving 1-cycle latency.
REQ-009 In IDLE, valid_i with load_i or store_i SHALL move the FSM to BUS, latch the operands, and clear all write flags on the outputs that edge.
REQ-010 In BUS, mem_req_o SHALL be high and mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o SHALL stay stable until the cycle mem_ack_i is sampled high.
REQ-011 Word access SHALL set mem_addr_o = {addr[31:2],2'b00} and mem_be_o = 4'b1111; byte access SHALL set mem_be_o = 1 << addr[1:0] and replicate store_data_i[7:0] on all four lanes.
REQ-012 On ack in BUS, the FSM SHALL enter DONE; mem_rdata_i SHALL be captured only on that ack edge.
REQ-013 In DONE, a load SHALL present write_dest_do_o=1, dest_o=latched dest, and result_o=load data; a byte load SHALL be zero-extended from lane addr[1:0].
REQ-014 In DONE, a store SHALL present all write flags low; the FSM SHALL return to IDLE after one DONE cycle.
REQ-015 stall_o SHALL be high from the IDLE->BUS edge until the BUS->DONE edge, and low in IDLE and DONE.
REQ-016 load_i and store_i both high SHALL be treated as a load.
REQ-017 valid_i low in IDLE SHALL drive all write flags low on the next edge and SHALL leave the data outputs holding their previous values.
REQ-018 write_cpsr_i SHALL pass through only on non-memory operations.

Reset
REQ-019 While rst is high, the block SHALL go to IDLE and clear every output to 0, including mem_req_o and stall_o.
REQ-020 rst asserted during BUS SHALL abandon the transaction without completing a write-back, and any mem_ack_i in that cycle SHALL be ignored.
REQ-021 Reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-022 With MEM_ACCESS_UNALIGNED_ROT_EN defined, a word load with addr[1:0]!=0 SHALL return the aligned word rotated right by 8*addr[1:0].
REQ-023 Without MEM_ACCESS_UNALIGNED_ROT_EN, unaligned word loads SHALL return the aligned word unrotated.

Structure
REQ-024 The FSM state encoding and the byte-enable width constant SHALL live in a shared package, alongside the pipeline's register-index width.
REQ-025 The lane selection, zero-extension and rotation logic SHALL be one sub-module, mem_align.

Verification
REQ-026 The bench SHALL cover: after reset, send a non-memory op with dest_i=3, write_dest_do_i=1, result_i=0x1234 -> next cycle dest_o=3, write_dest_do_o=1, result_o=0x1234, stall_o=0.
REQ-027 The bench SHALL cover: word load addr 0x100 with ack after 3 cycles and rdata 0xDEADBEEF -> stall_o high for 4 cycles, mem_be_o=4'hF, then result_o=0xDEADBEEF with write_dest_do_o=1.
REQ-028 The bench SHALL cover: byte store addr 0x203, data 0xAB -> mem_addr_o=0x200, mem_be_o=4'b1000, mem_wdata_o=0xABABABAB, and no write flags set in DONE.
REQ-029 The bench SHALL cover: byte load addr 0x302 with rdata 0x11223344 -> result_o=0x00000022.
REQ-030 The bench SHALL cover: word load addr 0x101 with rdata 0x11223344 -> result_o=0x44112233 with the macro defined, and 0x11223344 without it.
REQ-031 The bench SHALL cover: assert rst mid-BUS together with mem_ack_i -> next cycle mem_req_o=0, stall_o=0, and no write flags set.
